usb_frame_parser: RTL

// Parametrised successor to the fixed-map USB register loader. Parses the byte stream from async_receiver
// (frame "L N XX..X <CR|LF>") and streams nibble-packed words into NUM_CH channel FIFOs.

---
 rtl/usb_frame_parser_if.sv | 14 +
 rtl/usb_frame_parser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/usb_frame_parser_if.sv
// Byte stream from async_receiver in, shared FIFO write bus out.
interface usb_frame_parser_if #(
    parameter int NUM_CH = 7,
    parameter int WORD_W = 40
);
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic [WORD_W-1:0] wr_data;
    logic [NUM_CH-1:0] wr_req;
    logic [NUM_CH-1:0] sclr;

    modport master (output rx_ready, rx_data, input wr_data, wr_req, sclr);
    modport slave  (input rx_ready, rx_data, output wr_data, wr_req, sclr);
endinterface

// File: rtl/usb_frame_parser.sv
// Parses "L N XX..X <CR|LF>" frames into nibble-packed words for NUM_CH channel FIFOs,
// with line-count load, soft trigger, terminator check, inter-byte timeout and error pulses.
module usb_frame_parser #(
    parameter int NUM_CH      = 7,
    parameter int WORD_W      = 40,
    parameter int LINES_W     = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst,
    usb_frame_parser_if.slave  bus,
    output logic [LINES_W-1:0] rlines,
    output logic               soft_trig,
    output logic               frame_done,
    output logic [2:0]         err
);
    localparam int NIB       = (WORD_W + 3) / 4;
    localparam int LINES_NIB = (LINES_W + 3) / 4;
    localparam int CNT_MAX   = (NIB > LINES_NIB) ? NIB : LINES_NIB;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHAN, S_DATA, S_LINES, S_TRIG, S_EOL} state_t;

    state_t             state_q, state_d;
    logic [3:0]         ch_q, ch_d;
    logic [CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic [LINES_W-1:0] lines_cnt_q, lines_cnt_d;
    logic [LINES_W-1:0] lsh_q, lsh_d;
    logic [LINES_W-1:0] rlines_q, rlines_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [WORD_W-1:0]  wr_data_q, wr_data_d;
    logic [NUM_CH-1:0]  wr_req_q, wr_req_d;
    logic [NUM_CH-1:0]  sclr_q, sclr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               soft_trig_q, soft_trig_d;
    logic               frame_done_q, frame_done_d;
    logic [2:0]         err_q, err_d;

    logic [3:0]         nib;
    logic               is_data, is_eol;
    logic [WORD_W-1:0]  word_nx;
    logic [LINES_W-1:0] lsh_nx;

    assign nib     = bus.rx_data[3:0];
    assign is_data = (bus.rx_data[7:4] == 4'h3);
    assign is_eol  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    // MSB-first accumulation; high bits past the register width fall off
    assign word_nx = (shift_q << 4) | WORD_W'(nib);
    assign lsh_nx  = (lsh_q << 4) | LINES_W'(nib);

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        nib_cnt_d    = nib_cnt_q;
        lines_cnt_d  = lines_cnt_q;
        lsh_d        = lsh_q;
        shift_d      = shift_q;
        rlines_d     = rlines_q;
        wr_data_d    = wr_data_q;
        wr_req_d     = '0;
        sclr_d       = '0;
        soft_trig_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = '0;
        tmo_d        = (state_q == S_IDLE) ? '0 : tmo_q + TMO_W'(1);
        if (bus.rx_ready) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: if (bus.rx_data == 8'h4C) state_d = S_CHAN;
                S_CHAN: begin
                    ch_d        = nib;
                    nib_cnt_d   = '0;
                    lines_cnt_d = '0;
                    shift_d     = '0;
                    lsh_d       = '0;
                    if (32'(nib) < NUM_CH) begin
                        sclr_d  = NUM_CH'(1) << nib;
                        state_d = (rlines_q == '0) ? S_EOL : S_DATA;
                    end else if (nib == 4'hE) begin
                        state_d = S_LINES;
                    end else if (nib == 4'hF) begin
                        state_d = S_TRIG;
                    end else begin
                        err_d[0] = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_DATA, S_LINES, S_TRIG: begin
                    if (!is_data) begin
                        // early terminator = short frame; anything else = bad char
                        err_d[0] = !is_eol;
                        err_d[1] = is_eol;
                        state_d  = S_IDLE;
                    end else if (state_q == S_TRIG) begin
                        soft_trig_d = bus.rx_data[0];
                        state_d     = S_EOL;
                    end else if (state_q == S_LINES) begin
                        lsh_d     = lsh_nx;
                        nib_cnt_d = nib_cnt_q + CNT_W'(1);
                        if (nib_cnt_q == CNT_W'(LINES_NIB - 1)) begin
                            rlines_d = lsh_nx;
                            state_d  = S_EOL;
                        end
                    end else begin
                        shift_d   = word_nx;
                        nib_cnt_d = nib_cnt_q + CNT_W'(1);
                        if (nib_cnt_q == CNT_W'(NIB - 1)) begin
                            wr_data_d   = word_nx;
                            wr_req_d    = NUM_CH'(1) << ch_q;
                            lines_cnt_d = lines_cnt_q + LINES_W'(1);
                            nib_cnt_d   = '0;
                            shift_d     = '0;
                            if (lines_cnt_q + LINES_W'(1) == rlines_q) state_d = S_EOL;
                        end
                    end
                end
                S_EOL: begin
                    if (is_eol) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            err_d[2] = 1'b1;
            state_d  = S_IDLE;
            tmo_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            nib_cnt_q    <= '0;
            lines_cnt_q  <= '0;
            lsh_q        <= '0;
            shift_q      <= '0;
            rlines_q     <= '0;
            wr_data_q    <= '0;
            wr_req_q     <= '0;
            sclr_q       <= '0;
            tmo_q        <= '0;
            soft_trig_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            nib_cnt_q    <= nib_cnt_d;
            lines_cnt_q  <= lines_cnt_d;
            lsh_q        <= lsh_d;
            shift_q      <= shift_d;
            rlines_q     <= rlines_d;
            wr_data_q    <= wr_data_d;
            wr_req_q     <= wr_req_d;
            sclr_q       <= sclr_d;
            tmo_q        <= tmo_d;
            soft_trig_q  <= soft_trig_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.wr_data = wr_data_q;
    assign bus.wr_req  = wr_req_q;
    assign bus.sclr    = sclr_q;
    assign rlines      = rlines_q;
    assign soft_trig   = soft_trig_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
endmodule
